// File: rtl/dmem_arb_pkg.sv
// Shared types and counter widths for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    LOCKED   = 2'd1,
    COOLDOWN = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_t;

  // Counters are sized for the largest legal limits so any legal setting fits.
  localparam int STARVE_LIMIT_MAX = 15;
  localparam int LOCK_MAX_MAX     = 255;
  localparam int STARVE_W         = $clog2(STARVE_LIMIT_MAX + 1);
  localparam int LOCK_W           = $clog2(LOCK_MAX_MAX + 1);

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Core MEM-stage port, external debug/DMA port and data-memory port of the arbiter.
interface dmem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall;
  logic [DW-1:0] core_rdata;

  logic          ext_valid;
  logic          ext_we;
  logic          ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ready;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ext_valid, ext_we, ext_lock, ext_addr, ext_wdata,
    input  mem_rdata,
    output core_stall, core_rdata,
    output ext_ready, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ext_valid, ext_we, ext_lock, ext_addr, ext_wdata,
    output mem_rdata,
    input  core_stall, core_rdata,
    input  ext_ready, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter; clr and inc together load 1 so a count can restart in one cycle.
module arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] base;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    base    = clr ? '0 : cnt;
    cnt_nxt = (inc && (base != W'(MAX))) ? base + 1'b1 : base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core MEM stage and an external requester;
// the core has priority, the external port has starvation relief and a bounded lock.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic                core_gnt;
  logic                ext_gnt;
  logic                force_ext;
  logic [STARVE_W-1:0] starve_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                starve_clr;
  logic                starve_inc;
  logic                lock_clr;
  logic                lock_inc;
  logic                core_rd;
  logic                ext_rd;
  logic                rd_vld_p1;
  owner_t              rd_owner_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_gnt  = 1'b0;
    ext_gnt   = 1'b0;
    force_ext = 1'b0;
    case (state)
      ARB: begin
        force_ext = bus.ext_valid && (starve_cnt == STARVE_W'(STARVE_LIMIT));
        core_gnt  = bus.core_req && !force_ext;
        ext_gnt   = bus.ext_valid && !core_gnt;
        if (ext_gnt && bus.ext_lock) state_nxt = LOCKED;
      end
      LOCKED: begin
        ext_gnt = bus.ext_valid;
        if (!bus.ext_lock || (lock_cnt == LOCK_W'(LOCK_MAX))) state_nxt = COOLDOWN;
      end
      COOLDOWN: begin
        core_gnt  = bus.core_req;
        state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
    // Grants are forced low while reset is held so the memory sees no strobe.
    if (!reset) begin
      core_gnt = 1'b0;
      ext_gnt  = 1'b0;
    end
  end

  // Starvation count is frozen while the external port owns the lock.
  always_comb begin
    starve_clr = (state != LOCKED) && (ext_gnt || !bus.ext_valid);
    starve_inc = (state != LOCKED) && bus.ext_valid && !ext_gnt;
    lock_clr   = (state != LOCKED);
    lock_inc   = (state == LOCKED) || ((state == ARB) && ext_gnt && bus.ext_lock);
  end

  arb_sat_counter #(.W(STARVE_W), .MAX(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .cnt   (starve_cnt)
  );

  arb_sat_counter #(.W(LOCK_W), .MAX(LOCK_MAX)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (lock_clr),
    .inc   (lock_inc),
    .cnt   (lock_cnt)
  );

  assign core_rd = core_gnt && !bus.core_we;
  assign ext_rd  = ext_gnt && !bus.ext_we;

  // p1: read-return owner, aligned with the memory's one-cycle read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_p1   <= 1'b0;
      rd_owner_p1 <= OWN_CORE;
    end else begin
      rd_vld_p1 <= core_rd || ext_rd;
      if (core_rd || ext_rd) rd_owner_p1 <= core_rd ? OWN_CORE : OWN_EXT;
    end
  end

  assign bus.core_stall = bus.core_req && !core_gnt && reset;
  assign bus.core_rdata = (rd_vld_p1 && (rd_owner_p1 == OWN_CORE)) ? bus.mem_rdata : '0;
  assign bus.ext_ready  = ext_gnt;
  assign bus.ext_rvalid = rd_vld_p1 && (rd_owner_p1 == OWN_EXT);
  assign bus.ext_rdata  = reset ? bus.mem_rdata : '0;

  assign bus.mem_en    = core_gnt || ext_gnt;
  assign bus.mem_we    = core_gnt ? bus.core_we : (ext_gnt && bus.ext_we);
  assign bus.mem_addr  = core_gnt ? bus.core_addr : (ext_gnt ? bus.ext_addr : '0);
  assign bus.mem_wdata = core_gnt ? bus.core_wdata : (ext_gnt ? bus.ext_wdata : '0);

endmodule
